// File: rtl/vec_add_lane_sequencer.sv
// Vector add that time-multiplexes one registered-operand W-bit adder across N lanes.
// A job is captured whole on acceptance, then one lane pair per cycle goes through the adder.
// The result vector is held under valid/ready backpressure.
module vec_add_lane_sequencer #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a [N-1:0],
  input  logic [W-1:0] b [N-1:0],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y [N-1:0],
  output logic [N-1:0] carry,
  output logic         busy
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  tag_q, tag_d;
  logic [W-1:0]   ra_q, ra_d;
  logic [W-1:0]   rb_q, rb_d;
  logic [W-1:0]   abuf_q [N-1:0];
  logic [W-1:0]   abuf_d [N-1:0];
  logic [W-1:0]   bbuf_q [N-1:0];
  logic [W-1:0]   bbuf_d [N-1:0];
  logic [W-1:0]   y_q [N-1:0];
  logic [W-1:0]   y_d [N-1:0];
  logic [N-1:0]   carry_q, carry_d;
  logic [W:0]     sum;

  // Shared adder: zero-extended so bit W is the lane carry.
  assign sum = {1'b0, ra_q} + {1'b0, rb_q};

  // Next-state: sequence lanes through the adder; write back the lane loaded on the prior edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    abuf_d  = abuf_q;
    bbuf_d  = bbuf_q;
    y_d     = y_q;
    carry_d = carry_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          abuf_d  = a;
          bbuf_d  = b;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        ra_d  = abuf_q[idx_q];
        rb_d  = bbuf_q[idx_q];
        tag_d = idx_q;
        // On the first RUN edge nothing has been loaded yet, so nothing to write.
        if (idx_q != '0) begin
          y_d[tag_q]     = sum[W-1:0];
          carry_d[tag_q] = sum[W];
        end
        if (idx_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StDrain: begin
        y_d[tag_q]     = sum[W-1:0];
        carry_d[tag_q] = sum[W];
        state_d        = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tag_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      abuf_q  <= '{default: '0};
      bbuf_q  <= '{default: '0};
      y_q     <= '{default: '0};
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      abuf_q  <= abuf_d;
      bbuf_q  <= bbuf_d;
      y_q     <= y_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign y         = y_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_vec_add_lane_sequencer.sv
// Self-checking bench: randomized and directed jobs checked every cycle against a
// cycle-counting behavioural model of the lane sequencer.
module tb_vec_add_lane_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a [N-1:0];
  logic [W-1:0] b [N-1:0];
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y [N-1:0];
  logic [N-1:0] carry;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 = waiting for a job, 1 = computing (m_cnt edges since acceptance), 2 = result held.
  int         m_mode;
  int         m_cnt;
  logic [W:0] m_job [N];
  logic [W-1:0] m_y [N];
  logic       m_c [N];

  vec_add_lane_sequencer #(.W(W), .N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .carry    (carry),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_cnt  = 0;
    for (int i = 0; i < N; i++) begin
      m_y[i]   = '0;
      m_c[i]   = 1'b0;
      m_job[i] = '0;
    end
  endfunction

  // Lane k of an accepted job becomes visible after the (k+2)-th edge following acceptance;
  // the whole result is presented after edge N+1.
  function automatic void model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (in_valid) begin
        for (int i = 0; i < N; i++) m_job[i] = {1'b0, a[i]} + {1'b0, b[i]};
        m_cnt  = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt >= 2 && m_cnt <= N + 1) begin
        m_y[m_cnt-2] = m_job[m_cnt-2][W-1:0];
        m_c[m_cnt-2] = m_job[m_cnt-2][W];
      end
      if (m_cnt == N + 1) m_mode = 2;
    end else begin
      if (out_ready) m_mode = 0;
    end
  endfunction

  task automatic compare();
    check("in_ready", in_ready, m_mode == 0);
    check("out_valid", out_valid, m_mode == 2);
    check("busy", busy, m_mode != 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("y[%0d]", i), y[i], m_y[i]);
      check($sformatf("carry[%0d]", i), carry[i], m_c[i]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
  endtask

  task automatic wait_out_valid();
    int budget;
    budget = 3 * N;
    while (!out_valid && budget > 0) begin
      step();
      budget--;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  logic [W-1:0] ja [N];
  logic [W-1:0] jb [N];

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    step();
    step();
    reset = 1'b1;
    // Reset state, literal.
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_carry", carry, 0);

    // Directed job 1: plain sums, latency pinned with literals.
    for (int i = 0; i < N; i++) begin
      a[i] = W'(i + 1);
      b[i] = W'(10 * (i + 1));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      step();
      check("latency_early", out_valid, 0);
    end
    step();
    check("latency_e5", out_valid, 1);
    check("job1_y0", y[0], 11);
    check("job1_y1", y[1], 22);
    check("job1_y2", y[2], 33);
    check("job1_y3", y[3], 44);
    check("job1_carry", carry, 0);
    check("model_pin_y3", m_y[3], 44);
    step();
    check("job1_back_idle", in_ready, 1);

    // Directed job 2: wrap/carry lanes, then backpressure with ignored in_valid.
    a[0] = 255; b[0] = 1;
    a[1] = 5;   b[1] = 6;
    a[2] = 200; b[2] = 100;
    a[3] = 7;   b[3] = 8;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out_valid();
    check("wrap_y0", y[0], 0);
    check("wrap_y1", y[1], 11);
    check("wrap_y2", y[2], 44);
    check("wrap_y3", y[3], 15);
    check("wrap_carry", carry, 4'b0101);
    check("model_pin_c2", m_c[2], 1);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      randomize_ops();
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_carry", carry, 4'b0101);
      check("bp_y2", y[2], 44);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();

    // Async reset two edges into RUN.
    randomize_ops();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_carry", carry, 0);
    for (int i = 0; i < N; i++) check("arst_y", y[i], 0);
    step();
    reset = 1'b1;

    // Back-to-back jobs, in_valid held, operands scrambled every cycle after acceptance.
    randomize_ops();
    for (int i = 0; i < N; i++) begin
      ja[i] = a[i];
      jb[i] = b[i];
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    while (!out_valid && m_cnt < 3 * N) begin
      randomize_ops();
      step();
    end
    check("b2b_job1_valid", out_valid, 1);
    for (int i = 0; i < N; i++) begin
      check("b2b_job1_y", y[i], W'(ja[i] + jb[i]));
      check("b2b_job1_c", carry[i], ({1'b0, ja[i]} + {1'b0, jb[i]}) >> W);
    end
    randomize_ops();
    for (int i = 0; i < N; i++) begin
      ja[i] = a[i];
      jb[i] = b[i];
    end
    step();
    check("b2b_idle_gap", in_ready, 1);
    step();
    check("b2b_second_accepted", busy, 1);
    randomize_ops();
    wait_out_valid();
    for (int i = 0; i < N; i++) begin
      check("b2b_job2_y", y[i], W'(ja[i] + jb[i]));
      check("b2b_job2_c", carry[i], ({1'b0, ja[i]} + {1'b0, jb[i]}) >> W);
    end
    in_valid = 1'b0;
    step();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      randomize_ops();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
